// File: rtl/shift_pkg.sv
// Shared types and helpers for the parametrised multi-cycle shifter.
// Shift modes, FSM states and the per-cycle step-size helper.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_LSR = 2'd0,
    MODE_ASR = 2'd1,
    MODE_LSL = 2'd2,
    MODE_ROR = 2'd3
  } shift_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_t;

  // Bits moved this cycle: the full step, or whatever distance is left.
  function automatic int unsigned min_step(input int unsigned rem, input int unsigned step);
    return (rem < step) ? rem : step;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts value by k in the given mode and
// reports whether any bit was discarded (rotation never discards).
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int AW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  input  shift_mode_t      mode,
  input  logic [AW-1:0]    k,
  output logic [WIDTH-1:0] next_value,
  output logic             lost
);

  logic [2*WIDTH-1:0] ror_ext;
  logic [WIDTH-1:0]   low_mask;
  logic [WIDTH-1:0]   high_mask;

  always_comb begin
    low_mask   = ~({WIDTH{1'b1}} << k);
    high_mask  = ~({WIDTH{1'b1}} >> k);
    ror_ext    = {value, value} >> k;
    next_value = value;
    lost       = 1'b0;
    case (mode)
      MODE_LSR: begin
        next_value = value >> k;
        lost       = |(value & low_mask);
      end
      MODE_ASR: begin
        // The working MSB never changes under ASR, so it is the latched sign.
        next_value = $signed(value) >>> k;
        lost       = |(value & low_mask);
      end
      MODE_LSL: begin
        next_value = value << k;
        lost       = |(value & high_mask);
      end
      default: begin
        next_value = ror_ext[WIDTH-1:0];
        lost       = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_shift_unit.sv
// Multi-cycle WIDTH-bit shifter, STEP bits per clock, start/busy/done handshake.
// Optional sticky output (OR of discarded bits) enabled by SHIFT_STICKY_EN.
//
// Handshake: start is sampled on a rising edge whenever the unit is not in
// SHIFT (IDLE or DONE); busy is high from the next cycle through the done
// cycle; done is a one-cycle pulse and out/sticky hold until the next done.
module param_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output shift_state_t     dbg_state,
  output logic [WIDTH-1:0] out
`ifdef SHIFT_STICKY_EN
  ,
  output logic             sticky
`endif
);

  shift_state_t     state;
  shift_state_t     next_state;
  logic [WIDTH-1:0] work;
  logic [AW-1:0]    rem;
  shift_mode_t      mode_q;
  logic [AW-1:0]    k;
  logic [WIDTH-1:0] step_value;
  logic             step_lost;
  logic             accept;
  logic             last_step;

  assign accept    = start && (state != ST_SHIFT);
  assign k         = AW'(min_step(32'(rem), STEP));
  assign last_step = (state == ST_SHIFT) && (rem == k);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value      (work),
    .mode       (mode_q),
    .k          (k),
    .next_value (step_value),
    .lost       (step_lost)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) next_state = (amount == '0) ? ST_DONE : ST_SHIFT;
        else       next_state = ST_IDLE;
      end
      ST_SHIFT: begin
        if (rem == k) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      work   <= '0;
      rem    <= '0;
      mode_q <= MODE_LSR;
      out    <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        work   <= a;
        rem    <= amount;
        mode_q <= shift_mode_t'(mode);
        // A zero-distance request goes straight to DONE with the operand.
        if (amount == '0) out <= a;
      end else if (state == ST_SHIFT) begin
        work <= step_value;
        rem  <= rem - k;
        if (last_step) out <= step_value;
      end
    end
  end

`ifdef SHIFT_STICKY_EN
  logic sticky_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_acc <= 1'b0;
      sticky     <= 1'b0;
    end else if (accept) begin
      sticky_acc <= 1'b0;
      if (amount == '0) sticky <= 1'b0;
    end else if (state == ST_SHIFT) begin
      sticky_acc <= sticky_acc | step_lost;
      if (last_step) sticky <= sticky_acc | step_lost;
    end
  end
`else
  logic unused_lost;
  assign unused_lost = step_lost;
`endif

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule
